// File: rtl/sudoku_seq_ctrl_if.sv
// Signal bundle between the Sudoku sequencer, its user-event source and the datapath.
// The slave side is the sequencer; the master side drives events and returns solved.
interface sudoku_seq_ctrl_if;
  logic       new_game;
  logic       key_valid;
  logic [3:0] key_data;
  logic       check_req;
  logic       solved;
  logic       set_board_flag;
  logic       set_diff_flag;
  logic       cell_flag;
  logic       val_flag;
  logic       check_flag;
  logic [3:0] rand_setup;
  logic [3:0] rand_A;
  logic [3:0] rand_B;
  logic [3:0] diff_cell_val;
  logic       busy;
  logic       win;

  modport master (
    output new_game, key_valid, key_data, check_req, solved,
    input  set_board_flag, set_diff_flag, cell_flag, val_flag, check_flag,
    input  rand_setup, rand_A, rand_B, diff_cell_val, busy, win
  );

  modport slave (
    input  new_game, key_valid, key_data, check_req, solved,
    output set_board_flag, set_diff_flag, cell_flag, val_flag, check_flag,
    output rand_setup, rand_A, rand_B, diff_cell_val, busy, win
  );
endinterface

// File: rtl/sudoku_seq_ctrl.sv
// Sequencer ahead of the Sudoku datapath: turns user events into timed flag bursts,
// drives the shared operand bus and board seeds, and reports a win from solved.
module sudoku_seq_ctrl #(
  parameter int unsigned FLAG_CYCLES = 2,
  parameter logic [11:0] LFSR_SEED   = 12'h001
) (
  input  logic              clka,
  input  logic              restart_n,
  sudoku_seq_ctrl_if.slave  io
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_BOARD,
    S_WAIT_DIFF,
    S_DIFF,
    S_PLAY,
    S_CELL,
    S_WAIT_VAL,
    S_VAL,
    S_CHECK,
    S_CHECK_WAIT,
    S_DONE
  } state_e;

  localparam int unsigned        CW       = (FLAG_CYCLES > 1) ? $clog2(FLAG_CYCLES) : 1;
  localparam logic [CW-1:0]      CNT_LAST = CW'(FLAG_CYCLES - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [11:0]   lfsr_q, lfsr_d;
  logic [11:0]   rand_q, rand_d;
  logic [3:0]    dcv_q, dcv_d;
  logic          board_q, diff_q, cell_q, val_q, check_q, busy_q, win_q;
  logic          burst_last;

  // NOTE: every variable driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rand_d     = rand_q;
    dcv_d      = dcv_q;
    lfsr_d     = {lfsr_q[10:0], lfsr_q[11] ^ lfsr_q[5] ^ lfsr_q[3] ^ lfsr_q[0]};
    burst_last = (cnt_q == CNT_LAST);

    if (io.new_game) begin
      // Abort/start wins everywhere; seeds come from the pre-advance LFSR value.
      state_d = S_BOARD;
      cnt_d   = '0;
      rand_d  = lfsr_q;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_BOARD: begin
          cnt_d = burst_last ? '0 : cnt_q + 1'b1;
          if (burst_last) state_d = S_WAIT_DIFF;
        end
        S_WAIT_DIFF: begin
          if (io.key_valid && (io.key_data <= 4'd3)) begin
            dcv_d   = io.key_data;
            cnt_d   = '0;
            state_d = S_DIFF;
          end
        end
        S_DIFF: begin
          cnt_d = burst_last ? '0 : cnt_q + 1'b1;
          if (burst_last) state_d = S_PLAY;
        end
        S_PLAY: begin
          if (io.check_req) begin
            state_d = S_CHECK;
          end else if (io.key_valid) begin
            dcv_d   = io.key_data;
            cnt_d   = '0;
            state_d = S_CELL;
          end
        end
        S_CELL: begin
          cnt_d = burst_last ? '0 : cnt_q + 1'b1;
          if (burst_last) state_d = S_WAIT_VAL;
        end
        S_WAIT_VAL: begin
          if (io.key_valid && (io.key_data >= 4'd1) && (io.key_data <= 4'd4)) begin
            dcv_d   = io.key_data;
            cnt_d   = '0;
            state_d = S_VAL;
          end
        end
        S_VAL: begin
          cnt_d = burst_last ? '0 : cnt_q + 1'b1;
          if (burst_last) state_d = S_PLAY;
        end
        S_CHECK:      state_d = S_CHECK_WAIT;
        S_CHECK_WAIT: state_d = io.solved ? S_DONE : S_PLAY;
        S_DONE: ;
        default:      state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      lfsr_q  <= LFSR_SEED;
      rand_q  <= '0;
      dcv_q   <= '0;
      board_q <= 1'b0;
      diff_q  <= 1'b0;
      cell_q  <= 1'b0;
      val_q   <= 1'b0;
      check_q <= 1'b0;
      busy_q  <= 1'b0;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      rand_q  <= rand_d;
      dcv_q   <= dcv_d;
      // Outputs are decoded from the next state so they are registered yet in step.
      board_q <= (state_d == S_BOARD);
      diff_q  <= (state_d == S_DIFF);
      cell_q  <= (state_d == S_CELL);
      val_q   <= (state_d == S_VAL);
      check_q <= (state_d == S_CHECK);
      busy_q  <= state_d inside {S_BOARD, S_DIFF, S_CELL, S_VAL, S_CHECK, S_CHECK_WAIT};
      win_q   <= (state_d == S_DONE);
    end
  end

  assign io.set_board_flag = board_q;
  assign io.set_diff_flag  = diff_q;
  assign io.cell_flag      = cell_q;
  assign io.val_flag       = val_q;
  assign io.check_flag     = check_q;
  assign io.rand_setup     = rand_q[11:8];
  assign io.rand_A         = rand_q[7:4];
  assign io.rand_B         = rand_q[3:0];
  assign io.diff_cell_val  = dcv_q;
  assign io.busy           = busy_q;
  assign io.win            = win_q;

endmodule

// File: tb/tb_sudoku_seq_ctrl.sv
// Bench for sudoku_seq_ctrl: expected flag bursts are queued as stimulus is driven and
// compared against bursts recorded by a negedge monitor, plus cycle-level spot checks.
module tb_sudoku_seq_ctrl;

  typedef struct packed {
    logic [2:0]  id;      // 0 board, 1 diff, 2 cell, 3 val, 4 check
    logic [7:0]  len;
    logic [3:0]  bus;
    logic        stable;
    logic [11:0] rnd;
  } burst_t;

  logic clka = 1'b0;
  logic restart_n;
  int   n_chk = 0;
  int   n_pass = 0;
  logic [11:0] m_lfsr;
  logic [11:0] exp_rnd;
  logic [3:0]  exp_dcv;
  burst_t exp_q[$];
  burst_t obs_q[$];

  sudoku_seq_ctrl_if bus_if ();

  sudoku_seq_ctrl #(.FLAG_CYCLES(2), .LFSR_SEED(12'h001)) dut (
    .clka      (clka),
    .restart_n (restart_n),
    .io        (bus_if.slave)
  );

  always #5 clka = ~clka;

  always @(posedge clka or negedge restart_n) begin
    if (!restart_n) m_lfsr <= 12'h001;
    else m_lfsr <= {m_lfsr[10:0], m_lfsr[11] ^ m_lfsr[5] ^ m_lfsr[3] ^ m_lfsr[0]};
  end

  function automatic logic [4:0] flags();
    return {bus_if.check_flag, bus_if.val_flag, bus_if.cell_flag,
            bus_if.set_diff_flag, bus_if.set_board_flag};
  endfunction

  function automatic logic [11:0] rnd();
    return {bus_if.rand_setup, bus_if.rand_A, bus_if.rand_B};
  endfunction

  function automatic logic [22:0] outs();
    return {flags(), bus_if.busy, bus_if.win, rnd(), bus_if.diff_cell_val};
  endfunction

  function automatic burst_t mk(int id, int len, logic [3:0] b, logic [11:0] r);
    burst_t t;
    t.id = 3'(id); t.len = 8'(len); t.bus = b; t.stable = 1'b1; t.rnd = r;
    return t;
  endfunction

  // Burst monitor: records length, operand bus (and its stability) and final seeds.
  int          mlen[5];
  logic [3:0]  mbus[5];
  logic        mst[5];
  logic [11:0] mrnd[5];
  always @(negedge clka) begin
    logic [4:0] fl;
    burst_t     t;
    fl = flags();
    for (int i = 0; i < 5; i++) begin
      if (fl[i]) begin
        if (mlen[i] == 0) begin
          mbus[i] = bus_if.diff_cell_val;
          mst[i]  = 1'b1;
        end else if (bus_if.diff_cell_val !== mbus[i]) begin
          mst[i] = 1'b0;
        end
        mlen[i]++;
        mrnd[i] = rnd();
      end else if (mlen[i] > 0) begin
        t.id = 3'(i); t.len = 8'(mlen[i]); t.bus = mbus[i]; t.stable = mst[i]; t.rnd = mrnd[i];
        obs_q.push_back(t);
        mlen[i] = 0;
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clka);
  endtask

  task automatic key(logic [3:0] k);
    bus_if.key_valid = 1'b1;
    bus_if.key_data  = k;
    @(negedge clka);
    bus_if.key_valid = 1'b0;
  endtask

  task automatic get_burst(output burst_t b, output bit ok);
    ok = 1'b0;
    b  = '0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (obs_q.size() > 0) begin
        b  = obs_q.pop_front();
        ok = 1'b1;
      end else begin
        @(negedge clka);
        #1;
      end
    end
  endtask

  task automatic test_reset();
    burst_t e, g; bit ok;
    restart_n = 1'b0;
    #23;
    n_chk++; if (outs() !== 23'h0) $display("FAIL reset_outs got=%h exp=0", outs()); else n_pass++;
    @(negedge clka);
    restart_n = 1'b1;
    exp_dcv = 4'h0;
    cyc(2);
    bus_if.new_game = 1'b1;
    exp_rnd = 12'h007;
    exp_q.push_back(mk(0, 2, exp_dcv, exp_rnd));
    @(negedge clka);
    bus_if.new_game = 1'b0;
    n_chk++; if ({bus_if.set_board_flag, bus_if.busy} !== 2'b11)
      $display("FAIL board_c1 got=%b exp=11", {bus_if.set_board_flag, bus_if.busy}); else n_pass++;
    cyc(1);
    n_chk++; if (bus_if.set_board_flag !== 1'b1)
      $display("FAIL board_c2 got=%b exp=1", bus_if.set_board_flag); else n_pass++;
    cyc(1);
    n_chk++; if ({bus_if.set_board_flag, bus_if.busy} !== 2'b00)
      $display("FAIL wait_diff got=%b exp=00", {bus_if.set_board_flag, bus_if.busy}); else n_pass++;
    n_chk++; if (rnd() !== 12'h007) $display("FAIL rand_latch got=%h exp=007", rnd()); else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); get_burst(g, ok); n_chk++;
      if (!ok || g !== e) $display("FAIL reset_burst got=%h exp=%h ok=%0d", g, e, ok); else n_pass++;
    end
    cyc(2);
    n_chk++; if (obs_q.size() != 0) begin
      $display("FAIL reset_extra got=%0d exp=0", obs_q.size()); obs_q.delete();
    end else n_pass++;
  endtask

  task automatic test_diff();
    burst_t e, g; bit ok;
    key(4'd5);
    n_chk++; if (bus_if.set_diff_flag !== 1'b0)
      $display("FAIL diff_ignore got=%b exp=0", bus_if.set_diff_flag); else n_pass++;
    key(4'd2);
    exp_dcv = 4'd2;
    exp_q.push_back(mk(1, 2, exp_dcv, exp_rnd));
    n_chk++; if ({bus_if.set_diff_flag, bus_if.diff_cell_val} !== {1'b1, 4'd2})
      $display("FAIL diff_start got=%b/%h exp=1/2", bus_if.set_diff_flag, bus_if.diff_cell_val); else n_pass++;
    cyc(2);
    n_chk++; if ({bus_if.set_diff_flag, bus_if.busy} !== 2'b00)
      $display("FAIL diff_play got=%b exp=00", {bus_if.set_diff_flag, bus_if.busy}); else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); get_burst(g, ok); n_chk++;
      if (!ok || g !== e) $display("FAIL diff_burst got=%h exp=%h ok=%0d", g, e, ok); else n_pass++;
    end
    cyc(2);
    n_chk++; if (obs_q.size() != 0) begin
      $display("FAIL diff_extra got=%0d exp=0", obs_q.size()); obs_q.delete();
    end else n_pass++;
  endtask

  task automatic test_cell_val();
    burst_t e, g; bit ok;
    key(4'd9);
    exp_dcv = 4'd9;
    exp_q.push_back(mk(2, 2, exp_dcv, exp_rnd));
    n_chk++; if ({bus_if.cell_flag, bus_if.diff_cell_val} !== {1'b1, 4'd9})
      $display("FAIL cell_start got=%b/%h exp=1/9", bus_if.cell_flag, bus_if.diff_cell_val); else n_pass++;
    cyc(2);
    bus_if.check_req = 1'b1;
    @(negedge clka);
    bus_if.check_req = 1'b0;
    n_chk++; if ({bus_if.check_flag, bus_if.busy} !== 2'b00)
      $display("FAIL waitval_check got=%b exp=00", {bus_if.check_flag, bus_if.busy}); else n_pass++;
    key(4'd0);
    n_chk++; if (bus_if.val_flag !== 1'b0) $display("FAIL val_zero got=%b exp=0", bus_if.val_flag); else n_pass++;
    key(4'd3);
    exp_dcv = 4'd3;
    exp_q.push_back(mk(3, 2, exp_dcv, exp_rnd));
    n_chk++; if ({bus_if.val_flag, bus_if.diff_cell_val} !== {1'b1, 4'd3})
      $display("FAIL val_start got=%b/%h exp=1/3", bus_if.val_flag, bus_if.diff_cell_val); else n_pass++;
    cyc(2);
    n_chk++; if ({bus_if.val_flag, bus_if.busy} !== 2'b00)
      $display("FAIL val_play got=%b exp=00", {bus_if.val_flag, bus_if.busy}); else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); get_burst(g, ok); n_chk++;
      if (!ok || g !== e) $display("FAIL cellval_burst got=%h exp=%h ok=%0d", g, e, ok); else n_pass++;
    end
    cyc(2);
    n_chk++; if (obs_q.size() != 0) begin
      $display("FAIL cellval_extra got=%0d exp=0", obs_q.size()); obs_q.delete();
    end else n_pass++;
  endtask

  task automatic test_back_to_back();
    burst_t e, g; bit ok;
    key(4'd12);
    exp_dcv = 4'd12;
    exp_q.push_back(mk(2, 2, exp_dcv, exp_rnd));
    key(4'd1);
    key(4'd1);
    key(4'd4);
    exp_dcv = 4'd4;
    exp_q.push_back(mk(3, 2, exp_dcv, exp_rnd));
    n_chk++; if ({bus_if.val_flag, bus_if.diff_cell_val} !== {1'b1, 4'd4})
      $display("FAIL b2b_val got=%b/%h exp=1/4", bus_if.val_flag, bus_if.diff_cell_val); else n_pass++;
    cyc(2);
    n_chk++; if (bus_if.busy !== 1'b0) $display("FAIL b2b_play got=%b exp=0", bus_if.busy); else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); get_burst(g, ok); n_chk++;
      if (!ok || g !== e) $display("FAIL b2b_burst got=%h exp=%h ok=%0d", g, e, ok); else n_pass++;
    end
    cyc(2);
    n_chk++; if (obs_q.size() != 0) begin
      $display("FAIL b2b_extra got=%0d exp=0", obs_q.size()); obs_q.delete();
    end else n_pass++;
  endtask

  task automatic test_check();
    burst_t e, g; bit ok;
    bus_if.solved    = 1'b0;
    bus_if.check_req = 1'b1;
    bus_if.key_valid = 1'b1;
    bus_if.key_data  = 4'd5;
    @(negedge clka);
    bus_if.check_req = 1'b0;
    bus_if.key_valid = 1'b0;
    exp_q.push_back(mk(4, 1, exp_dcv, exp_rnd));
    n_chk++; if ({bus_if.check_flag, bus_if.cell_flag, bus_if.busy} !== 3'b101)
      $display("FAIL check_c1 got=%b exp=101", {bus_if.check_flag, bus_if.cell_flag, bus_if.busy}); else n_pass++;
    cyc(1);
    n_chk++; if ({bus_if.check_flag, bus_if.busy} !== 2'b01)
      $display("FAIL check_wait got=%b exp=01", {bus_if.check_flag, bus_if.busy}); else n_pass++;
    cyc(1);
    n_chk++; if ({bus_if.busy, bus_if.win} !== 2'b00)
      $display("FAIL check_unsolved got=%b exp=00", {bus_if.busy, bus_if.win}); else n_pass++;
    bus_if.solved    = 1'b1;
    bus_if.check_req = 1'b1;
    @(negedge clka);
    bus_if.check_req = 1'b0;
    exp_q.push_back(mk(4, 1, exp_dcv, exp_rnd));
    cyc(1);
    n_chk++; if (bus_if.win !== 1'b0) $display("FAIL win_early got=%b exp=0", bus_if.win); else n_pass++;
    cyc(1);
    n_chk++; if ({bus_if.win, bus_if.busy} !== 2'b10)
      $display("FAIL win_rise got=%b exp=10", {bus_if.win, bus_if.busy}); else n_pass++;
    key(4'd2);
    bus_if.check_req = 1'b1;
    cyc(1);
    bus_if.check_req = 1'b0;
    cyc(1);
    n_chk++; if ({bus_if.win, flags()} !== 6'b100000)
      $display("FAIL done_hold got=%b exp=100000", {bus_if.win, flags()}); else n_pass++;
    bus_if.solved = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); get_burst(g, ok); n_chk++;
      if (!ok || g !== e) $display("FAIL check_burst got=%h exp=%h ok=%0d", g, e, ok); else n_pass++;
    end
    cyc(2);
    n_chk++; if (obs_q.size() != 0) begin
      $display("FAIL check_extra got=%0d exp=0", obs_q.size()); obs_q.delete();
    end else n_pass++;
  endtask

  task automatic test_abort();
    burst_t e, g; bit ok;
    bus_if.new_game = 1'b1;
    exp_rnd = m_lfsr;
    @(negedge clka);
    bus_if.new_game = 1'b0;
    exp_q.push_back(mk(0, 2, exp_dcv, exp_rnd));
    n_chk++; if ({bus_if.win, bus_if.set_board_flag} !== 2'b01)
      $display("FAIL abort_done got=%b exp=01", {bus_if.win, bus_if.set_board_flag}); else n_pass++;
    cyc(2);
    key(4'd1); exp_dcv = 4'd1; exp_q.push_back(mk(1, 2, exp_dcv, exp_rnd));
    cyc(2);
    key(4'd5); exp_dcv = 4'd5; exp_q.push_back(mk(2, 2, exp_dcv, exp_rnd));
    cyc(2);
    key(4'd2); exp_dcv = 4'd2; exp_q.push_back(mk(3, 2, exp_dcv, exp_rnd));
    cyc(1);
    bus_if.new_game = 1'b1;
    exp_rnd = m_lfsr;
    @(negedge clka);
    bus_if.new_game = 1'b0;
    exp_q.push_back(mk(0, 2, exp_dcv, exp_rnd));
    n_chk++; if ({bus_if.val_flag, bus_if.set_board_flag} !== 2'b01)
      $display("FAIL abort_val got=%b exp=01", {bus_if.val_flag, bus_if.set_board_flag}); else n_pass++;
    n_chk++; if (rnd() !== exp_rnd) $display("FAIL abort_rand got=%h exp=%h", rnd(), exp_rnd); else n_pass++;
    cyc(2);
    key(4'd0); exp_dcv = 4'd0; exp_q.push_back(mk(1, 2, exp_dcv, exp_rnd));
    cyc(2);
    key(4'd6); exp_dcv = 4'd6; exp_q.push_back(mk(2, 1, exp_dcv, exp_rnd));
    bus_if.new_game = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_rnd = m_lfsr;
      @(negedge clka);
    end
    bus_if.new_game = 1'b0;
    exp_q.push_back(mk(0, 4, exp_dcv, exp_rnd));
    n_chk++; if ({bus_if.cell_flag, bus_if.set_board_flag} !== 2'b01)
      $display("FAIL abort_cell got=%b exp=01", {bus_if.cell_flag, bus_if.set_board_flag}); else n_pass++;
    n_chk++; if (rnd() !== exp_rnd) $display("FAIL held_rand got=%h exp=%h", rnd(), exp_rnd); else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); get_burst(g, ok); n_chk++;
      if (!ok || g !== e) $display("FAIL abort_burst got=%h exp=%h ok=%0d", g, e, ok); else n_pass++;
    end
    cyc(2);
    n_chk++; if (obs_q.size() != 0) begin
      $display("FAIL abort_extra got=%0d exp=0", obs_q.size()); obs_q.delete();
    end else n_pass++;
  endtask

  task automatic test_async_reset();
    burst_t e, g; bit ok;
    key(4'd3); exp_dcv = 4'd3; exp_q.push_back(mk(1, 2, exp_dcv, exp_rnd));
    cyc(2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); get_burst(g, ok); n_chk++;
      if (!ok || g !== e) $display("FAIL areset_burst got=%h exp=%h ok=%0d", g, e, ok); else n_pass++;
    end
    @(negedge clka);
    key(4'd8);
    n_chk++; if (bus_if.cell_flag !== 1'b1) $display("FAIL areset_cell got=%b exp=1", bus_if.cell_flag); else n_pass++;
    #2;
    restart_n = 1'b0;
    #1;
    n_chk++; if (outs() !== 23'h0) $display("FAIL async_clear got=%h exp=0", outs()); else n_pass++;
    cyc(2);
    obs_q.delete();
    exp_q.delete();
    restart_n = 1'b1;
    exp_dcv = 4'h0;
    bus_if.key_valid = 1'b1;
    bus_if.key_data  = 4'd2;
    @(negedge clka);
    bus_if.key_valid = 1'b0;
    n_chk++; if ({flags(), bus_if.busy} !== 6'b0)
      $display("FAIL idle_after_reset got=%b exp=000000", {flags(), bus_if.busy}); else n_pass++;
    bus_if.new_game = 1'b1;
    @(negedge clka);
    bus_if.new_game = 1'b0;
    exp_q.push_back(mk(0, 2, exp_dcv, 12'h003));
    n_chk++; if ({bus_if.set_board_flag, rnd()} !== {1'b1, 12'h003})
      $display("FAIL lfsr_restart got=%b/%h exp=1/003", bus_if.set_board_flag, rnd()); else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); get_burst(g, ok); n_chk++;
      if (!ok || g !== e) $display("FAIL restart_burst got=%h exp=%h ok=%0d", g, e, ok); else n_pass++;
    end
    cyc(2);
    n_chk++; if (obs_q.size() != 0) begin
      $display("FAIL restart_extra got=%0d exp=0", obs_q.size()); obs_q.delete();
    end else n_pass++;
  endtask

  initial begin
    restart_n        = 1'b0;
    bus_if.new_game  = 1'b0;
    bus_if.key_valid = 1'b0;
    bus_if.key_data  = 4'h0;
    bus_if.check_req = 1'b0;
    bus_if.solved    = 1'b0;
    exp_dcv          = 4'h0;
    exp_rnd          = 12'h000;
    test_reset();
    test_diff();
    test_cell_val();
    test_back_to_back();
    test_check();
    test_abort();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sudoku_seq_ctrl.md
# sudoku_seq_ctrl

Single-clock sequencer that sits directly upstream of the Sudoku datapath `dp`. It turns user events (new game, key entries, check request) into the timed flag bursts and shared operand bus the datapath consumes. It supplies the datapath's board-generation seeds from a free-running LFSR. It reads back `solved` to report a win.

## Interface

Parameters:
- `FLAG_CYCLES`, default 2: cycles each set_board/set_diff/cell/val flag stays high.
- `LFSR_SEED`, default 12'h001: LFSR reset value; must be nonzero.

Ports:
- `clka` input 1: sole clock. All state updates on the rising edge.
- `restart_n` input 1: asynchronous, active-low reset.
- `new_game` input 1: level sampled each edge; starts or aborts a game.
- `key_valid` input 1: one-cycle strobe qualifying `key_data`.
- `key_data` input 4: difficulty, cell index or value, depending on state.
- `check_req` input 1: request a solution check.
- `solved` input 1: from `dp`.
- `set_board_flag`, `set_diff_flag`, `cell_flag`, `val_flag`, `check_flag` output 1 each: to `dp`.
- `rand_setup`, `rand_A`, `rand_B` output 4 each: board seeds to `dp`.
- `diff_cell_val` output 4: shared operand bus to `dp`.
- `busy` output 1: high while any flag burst or check is in progress.
- `win` output 1: high in DONE.

## Operation

- All outputs are registered.
- Reset value of every output is 0. The LFSR resets to `LFSR_SEED` and the FSM to IDLE.
- LFSR:
  - 12-bit Fibonacci, advances every cycle out of reset, in every state.
  - Next value = {lfsr[10:0], lfsr[11]^lfsr[5]^lfsr[3]^lfsr[0]}.
  - Sequence from 001: 001, 003, 007, 00F, 01E, ...
- FSM states:
  - IDLE.
  - BOARD: set_board_flag burst.
  - WAIT_DIFF.
  - DIFF: set_diff_flag burst.
  - PLAY.
  - CELL: cell_flag burst.
  - WAIT_VAL.
  - VAL: val_flag burst.
  - CHECK: check_flag, 1 cycle.
  - CHECK_WAIT: 1 cycle.
  - DONE.
- `new_game`:
  - Has top priority in every state, including mid-burst.
  - On the same edge it latches rand_setup=lfsr[11:8], rand_A=lfsr[7:4], rand_B=lfsr[3:0], using the pre-advance LFSR value, and enters BOARD.
  - Any flag in progress drops on that edge.
- BOARD → WAIT_DIFF after `FLAG_CYCLES`.
- WAIT_DIFF:
  - `key_valid` with key_data ≤ 3 → latch diff_cell_val=key_data, enter DIFF.
  - key_data > 3 is ignored.
- DIFF → PLAY after `FLAG_CYCLES`.
- PLAY:
  - `check_req` → CHECK. It wins over a simultaneous `key_valid`; the key is dropped.
  - Otherwise `key_valid` → latch diff_cell_val=key_data (any 0..15), enter CELL.
- CELL → WAIT_VAL after `FLAG_CYCLES`.
- WAIT_VAL:
  - `key_valid` with key_data in 1..4 → latch diff_cell_val, enter VAL.
  - Other values are ignored.
  - `check_req` is ignored here.
- VAL → PLAY after `FLAG_CYCLES`.
- CHECK: check_flag high for exactly one cycle → CHECK_WAIT.
- CHECK_WAIT: sample `solved`. 1 → DONE, 0 → PLAY.
- DONE: `win`=1. Holds until `new_game`; key and check inputs are ignored.
- Holding of outputs:
  - `diff_cell_val` and the rand outputs hold their last latched value outside bursts.
  - Only the flags return to 0.
- `busy` = state ∈ {BOARD, DIFF, CELL, VAL, CHECK, CHECK_WAIT}.
- Inputs arriving during a burst are dropped; there is no queuing.

## Timing

- Trigger sampled at edge N:
  - The flag is high from after edge N through edge N+FLAG_CYCLES, then low.
  - The next WAIT/PLAY state is active from after edge N+FLAG_CYCLES.
- `diff_cell_val` is stable for the whole burst and changes only on the trigger edge.
- Check:
  - `check_req` at edge N → check_flag high for cycle N+1 only.
  - `solved` is sampled at edge N+2.
  - `win` rises after N+2 if solved.
- Back-to-back: a key accepted in WAIT_VAL on the first cycle after CELL ends is legal. The minimum cell+value entry is 2·FLAG_CYCLES+2 cycles.
- Reset asserted mid-burst: all flags drop immediately (asynchronous). After release the FSM is in IDLE and the LFSR restarts at the seed.
- `new_game` held high for multiple cycles: BOARD is re-entered every cycle, so the burst extends and the rand outputs re-latch each cycle. The final snapshot is the one taken on the last high edge.

## Test plan

- **Reset values:** reset, then release; hold `new_game` low for 2 edges, high on the 3rd → rand_setup=0, rand_A=0, rand_B=7. set_board_flag is high exactly 2 cycles, then the FSM is in WAIT_DIFF with busy=0.
- **Difficulty entry:** key_data=5 → ignored, no set_diff_flag. key_data=2 → diff_cell_val=2, set_diff_flag 2 cycles, then PLAY.
- **Cell and value entry:** cell 9 then value 0 → no val_flag. Value 3 → cell_flag 2 cycles with bus=9, then val_flag 2 cycles with bus=3, back to PLAY.
- **Simultaneous check and key in PLAY:** `check_req` and `key_valid` on the same edge → check_flag exactly 1 cycle, no cell_flag. With solved=0 the FSM returns to PLAY with win=0; with solved=1, win=1 two edges after the request.
- **Abort mid-burst:** `new_game` during the 2nd cycle of val_flag → val_flag low next cycle, set_board_flag high, rand outputs re-latched.
- **Async reset mid-burst:** pull `restart_n` low during cell_flag → all outputs 0 without a clock edge. After release, LFSR=001 and the FSM is in IDLE.
